counter_bank: RTL and testbench
===============================

# counter_bank

Parametrised bank of CHANNELS independent up/down counters that replaces the single-register counter in the button-press path. Each channel has its own programmable upper limit, plus wrap-or-saturate behaviour and registered overflow/underflow events. One command per cycle is applied to the channel addressed by `ch_sel`. A combinational read port and per-channel status vectors feed the display and control logic.

## Interface
- `DATA_WIDTH`, default 8: width of every counter value and limit.
- `CHANNELS`, default 4: number of counter channels, minimum 1.
- `SATURATE`, default 0: 0 = wrap at the bounds, 1 = hold at the bounds.
- `CH_W`, derived localparam: max(1, clog2(CHANNELS)).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `ch_sel`  in  CH_W  target channel of `ctrl`.
- `ctrl`  in  3  command: 0 NONE, 1 CLR, 2 LOAD, 3 INCR, 4 DECR, 5 CLR_ALL, 6 SET_LIMIT, 7 NONE (reserved).
- `data_input`  in  DATA_WIDTH  operand for LOAD and SET_LIMIT.
- `rd_sel`  in  CH_W  read-port channel select.
- `data_output`  out  DATA_WIDTH  value of channel `rd_sel`, combinational from registered state.
- `zero`  out  CHANNELS  bit i = (value[i] == 0).
- `at_limit`  out  CHANNELS  bit i = (value[i] == limit[i]).
- `ovf`  out  CHANNELS  registered one-cycle pulse: INCR at limit on channel i.
- `unf`  out  CHANNELS  registered one-cycle pulse: DECR at 0 on channel i.
- `sel_err`  out  1  registered one-cycle pulse: non-NONE command with `ch_sel` >= CHANNELS.

## Operation
- Reset state:
  - all values = 0.
  - all limits = all ones.
  - `ovf`, `unf`, `sel_err` = 0.
  - after reset: `zero` = all ones; `at_limit` = 0; `data_output` = 0.
- CLR: value[ch_sel] = 0. Limit unchanged.
- CLR_ALL: every value = 0, regardless of `ch_sel`. Limits unchanged. Never raises `sel_err`.
- LOAD: value[ch_sel] = min(data_input, limit[ch_sel]).
- SET_LIMIT:
  - limit[ch_sel] = data_input.
  - If the current value > data_input, the value is clamped to data_input on the same edge.
  - A limit of 0 is legal: the channel is pinned at 0.
- INCR:
  - value < limit: value + 1.
  - value == limit: SATURATE=0 gives 0; SATURATE=1 holds the value. The `ovf` bit pulses in both modes.
- DECR:
  - value > 0: value − 1.
  - value == 0: SATURATE=0 gives limit; SATURATE=1 holds at 0. The `unf` bit pulses in both modes.
- Arithmetic is unsigned, modulo 2^DATA_WIDTH. The compare against limit prevents natural overflow past limit.
- Out-of-range `ch_sel` (non-power-of-2 CHANNELS): the command is ignored, no state changes, and `sel_err` pulses. CLR_ALL still executes.
- Out-of-range `rd_sel`: `data_output` = 0.
- Only the addressed channel changes, except under CLR_ALL. Channels without a command hold their state.

## Timing
- Command sampled at rising edge N. The new value is visible on `data_output`/`zero`/`at_limit` in cycle N+1 (one-cycle latency).
- `ovf`/`unf`/`sel_err` are high for exactly cycle N+1. Back-to-back wrapping commands keep the bit high on consecutive cycles.
- Read port: pure combinational mux of registered values. A change of `rd_sel` is reflected in the same cycle.
- Async reset asserted mid-operation clears all state immediately, independent of `clk`. The command present at the first edge after deassertion is executed normally.
- No handshake: every command is accepted every cycle.

## Structure
- Package `counter_bank_pkg`:
  - ctrl encodings (CTRL_NONE … CTRL_SET_LIMIT).
  - `ctrl_t` 3-bit type.
  - clog2 helper function.
- Sub-module `counter_channel` (DATA_WIDTH, SATURATE):
  - contains the value/limit registers, next-state logic and ovf/unf flops.
  - inputs: `clk`, `rst`, `ctrl`, `sel`, `data_input`.
  - outputs: value, `zero`, `at_limit`, `ovf`, `unf`.
- Top:
  - decodes `ch_sel` into per-channel `sel`.
  - generates CHANNELS instances.
  - contains the `sel_err` flop and the read mux.

## Test plan
Bench parameters: DATA_WIDTH=4, CHANNELS=3, run with both SATURATE values.
- Reset then idle: `data_output`=0 for every `rd_sel`, `zero`=3'b111, `at_limit`=0, no pulses.
- SET_LIMIT ch1=5, LOAD ch1=9, then INCR ch1:
  - the LOAD reads back 5 (clamped);
  - INCR gives 0 with `ovf`=3'b010 for one cycle when SATURATE=0;
  - INCR holds 5 with the same `ovf` pulse when SATURATE=1.
- DECR ch0 from 0:
  - SATURATE=0: value becomes 15 (default limit), `unf`=3'b001;
  - SATURATE=1: value stays 0, `unf`=3'b001.
- LOAD ch2=12, then SET_LIMIT ch2=7: value reads 7 next cycle, `at_limit`[2]=1. Channels 0/1 are unchanged.
- INCR with `ch_sel`=3: no value changes, `sel_err` high for one cycle. CLR_ALL with `ch_sel`=3: all values 0, no `sel_err`.
- Assert `rst` asynchronously between edges while channels hold 4/5/6: all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg
// Shared definitions for the counter bank: command encodings, the command
// type and a ceil(log2) helper used to size channel-select ports.
package counter_bank_pkg;

  typedef logic [2:0] ctrl_t;

  localparam ctrl_t CTRL_NONE      = 3'd0;
  localparam ctrl_t CTRL_CLR       = 3'd1;
  localparam ctrl_t CTRL_LOAD      = 3'd2;
  localparam ctrl_t CTRL_INCR      = 3'd3;
  localparam ctrl_t CTRL_DECR      = 3'd4;
  localparam ctrl_t CTRL_CLR_ALL   = 3'd5;
  localparam ctrl_t CTRL_SET_LIMIT = 3'd6;
  localparam ctrl_t CTRL_RSVD      = 3'd7;

  // ceil(log2(n)), never less than 1 so a single-channel bank still has a
  // 1-bit select port.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/counter_channel.sv
// counter_channel
// One up/down counter with a programmable upper limit.
// Ports:
//   clk, rst       : clock, asynchronous active-high reset
//   ctrl           : command broadcast to every channel
//   sel            : this channel is the (in-range) target of ctrl
//   data_input     : operand for LOAD / SET_LIMIT
//   value          : registered counter value
//   zero, at_limit : combinational status of the registered state
//   ovf, unf       : registered one-cycle event pulses
module counter_channel
  import counter_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int SATURATE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  ctrl_t                 ctrl,
  input  logic                  sel,
  input  logic [DATA_WIDTH-1:0] data_input,
  output logic [DATA_WIDTH-1:0] value,
  output logic                  zero,
  output logic                  at_limit,
  output logic                  ovf,
  output logic                  unf
);

  logic [DATA_WIDTH-1:0] value_q, value_d;
  logic [DATA_WIDTH-1:0] limit_q, limit_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  always_comb begin
    value_d = value_q;
    limit_d = limit_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    // CLR_ALL acts on every channel whether or not this one is addressed.
    if (ctrl == CTRL_CLR_ALL) begin
      value_d = '0;
    end else if (sel) begin
      case (ctrl)
        CTRL_CLR: value_d = '0;
        CTRL_LOAD: value_d = (data_input > limit_q) ? limit_q : data_input;
        CTRL_INCR: begin
          if (value_q == limit_q) begin
            ovf_d   = 1'b1;
            value_d = (SATURATE != 0) ? value_q : '0;
          end else begin
            value_d = value_q + 1'b1;
          end
        end
        CTRL_DECR: begin
          if (value_q == '0) begin
            unf_d   = 1'b1;
            value_d = (SATURATE != 0) ? '0 : limit_q;
          end else begin
            value_d = value_q - 1'b1;
          end
        end
        CTRL_SET_LIMIT: begin
          limit_d = data_input;
          // Keep value <= limit as an invariant.
          if (value_q > data_input) value_d = data_input;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
      limit_q <= '1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      limit_q <= limit_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign value    = value_q;
  assign zero     = (value_q == '0);
  assign at_limit = (value_q == limit_q);
  assign ovf      = ovf_q;
  assign unf      = unf_q;

endmodule

// File: rtl/counter_bank.sv
// counter_bank
// Bank of CHANNELS independent up/down counters with per-channel limits.
// One command per cycle is applied to channel ch_sel; no handshake, every
// command is accepted. Results are visible one cycle after the sampling edge.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   ch_sel      : target channel of ctrl
//   ctrl        : command (see counter_bank_pkg encodings)
//   data_input  : operand for LOAD / SET_LIMIT
//   rd_sel      : read-port channel select
//   data_output : value of channel rd_sel (0 when out of range), combinational
//   zero        : per-channel value == 0
//   at_limit    : per-channel value == limit
//   ovf, unf    : per-channel registered wrap/saturate event pulses
//   sel_err     : registered pulse for a command addressed to a missing channel
module counter_bank
  import counter_bank_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int CHANNELS   = 4,
  parameter  int SATURATE   = 0,
  localparam int CH_W       = clog2_min1(CHANNELS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [CH_W-1:0]       ch_sel,
  input  ctrl_t                 ctrl,
  input  logic [DATA_WIDTH-1:0] data_input,
  input  logic [CH_W-1:0]       rd_sel,
  output logic [DATA_WIDTH-1:0] data_output,
  output logic [CHANNELS-1:0]   zero,
  output logic [CHANNELS-1:0]   at_limit,
  output logic [CHANNELS-1:0]   ovf,
  output logic [CHANNELS-1:0]   unf,
  output logic                  sel_err
);

  logic [CHANNELS-1:0]   sel;
  logic [DATA_WIDTH-1:0] values [CHANNELS];
  logic                  is_nop;
  logic                  sel_err_q, sel_err_d;

  assign is_nop = (ctrl == CTRL_NONE) || (ctrl == CTRL_RSVD);

  // One-hot decode; an out-of-range ch_sel selects nothing.
  always_comb begin
    sel = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      sel[i] = (int'(ch_sel) == i);
    end
  end

  // CLR_ALL is channel-independent, so it never counts as a bad select.
  always_comb begin
    sel_err_d = !is_nop && (ctrl != CTRL_CLR_ALL) && (int'(ch_sel) >= CHANNELS);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sel_err_q <= 1'b0;
    else     sel_err_q <= sel_err_d;
  end

  assign sel_err = sel_err_q;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    counter_channel #(
      .DATA_WIDTH(DATA_WIDTH),
      .SATURATE  (SATURATE)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .ctrl      (ctrl),
      .sel       (sel[g]),
      .data_input(data_input),
      .value     (values[g]),
      .zero      (zero[g]),
      .at_limit  (at_limit[g]),
      .ovf       (ovf[g]),
      .unf       (unf[g])
    );
  end

  always_comb begin
    data_output = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(rd_sel) == i) data_output = values[i];
    end
  end

endmodule

// File: tb/tb_counter_bank.sv
// tb_counter_bank
// Two counter_bank instances (wrap and saturate) share one stimulus stream
// and are checked against an array-based model of the counter rules.
module tb_counter_bank;
  import counter_bank_pkg::*;

  localparam int DW = 4;
  localparam int CH = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    ch_sel = '0;
  ctrl_t         ctrl = CTRL_NONE;
  logic [DW-1:0] data_input = '0;
  logic [1:0]    rd_sel = '0;

  logic [DW-1:0] dout_o [2];
  logic [CH-1:0] zero_o [2];
  logic [CH-1:0] atl_o  [2];
  logic [CH-1:0] ovf_o  [2];
  logic [CH-1:0] unf_o  [2];
  logic          err_o  [2];

  int vectors = 0;
  int miscompares = 0;

  // model state: [instance][channel], instance 0 wraps, instance 1 saturates
  logic [DW-1:0] m_val [2][CH];
  logic [DW-1:0] m_lim [2][CH];
  logic [CH-1:0] m_ovf [2];
  logic [CH-1:0] m_unf [2];
  logic          m_err;

  always #5 clk = ~clk;

  counter_bank #(.DATA_WIDTH(DW), .CHANNELS(CH), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .ch_sel(ch_sel), .ctrl(ctrl), .data_input(data_input),
    .rd_sel(rd_sel), .data_output(dout_o[0]), .zero(zero_o[0]),
    .at_limit(atl_o[0]), .ovf(ovf_o[0]), .unf(unf_o[0]), .sel_err(err_o[0])
  );

  counter_bank #(.DATA_WIDTH(DW), .CHANNELS(CH), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .ch_sel(ch_sel), .ctrl(ctrl), .data_input(data_input),
    .rd_sel(rd_sel), .data_output(dout_o[1]), .zero(zero_o[1]),
    .at_limit(atl_o[1]), .ovf(ovf_o[1]), .unf(unf_o[1]), .sel_err(err_o[1])
  );

  // ---------------- reference model ----------------
  task automatic model_reset();
    for (int s = 0; s < 2; s++) begin
      for (int c = 0; c < CH; c++) begin
        m_val[s][c] = 0;
        m_lim[s][c] = 15;
      end
      m_ovf[s] = 0;
      m_unf[s] = 0;
    end
    m_err = 0;
  endtask

  task automatic model_step(input int c, input int ch, input int d);
    int v, l;
    m_err = 0;
    for (int s = 0; s < 2; s++) begin
      m_ovf[s] = 0;
      m_unf[s] = 0;
      if (c == 5) begin
        for (int k = 0; k < CH; k++) m_val[s][k] = 0;
      end else if (c >= 1 && c <= 6) begin
        if (ch >= CH) begin
          m_err = 1;
        end else begin
          v = int'(m_val[s][ch]);
          l = int'(m_lim[s][ch]);
          if (c == 1) v = 0;
          if (c == 2) v = (d < l) ? d : l;
          if (c == 3) begin
            if (v == l) begin
              m_ovf[s][ch] = 1'b1;
              if (s == 0) v = 0;
            end else v = v + 1;
          end
          if (c == 4) begin
            if (v == 0) begin
              m_unf[s][ch] = 1'b1;
              if (s == 0) v = l;
            end else v = v - 1;
          end
          if (c == 6) begin
            l = d;
            if (v > d) v = d;
          end
          m_val[s][ch] = v[DW-1:0];
          m_lim[s][ch] = l[DW-1:0];
        end
      end
    end
  endtask

  function automatic logic [CH-1:0] exp_zero(input int s);
    logic [CH-1:0] r;
    for (int k = 0; k < CH; k++) r[k] = (m_val[s][k] == 0);
    return r;
  endfunction

  function automatic logic [CH-1:0] exp_atl(input int s);
    logic [CH-1:0] r;
    for (int k = 0; k < CH; k++) r[k] = (m_val[s][k] == m_lim[s][k]);
    return r;
  endfunction

  function automatic logic [DW-1:0] exp_rd(input int s, input int rd);
    if (rd < CH) return m_val[s][rd];
    return '0;
  endfunction

  // ---------------- driver ----------------
  // Apply one command at the next rising edge; returns 1 time unit after it.
  task automatic cmd(input int c, input int ch, input int d);
    @(negedge clk);
    ctrl       = ctrl_t'(c);
    ch_sel     = ch[1:0];
    data_input = d[DW-1:0];
    @(posedge clk);
    model_step(c, ch, d);
    #1;
    ctrl = CTRL_NONE;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    cmd(0, 0, 0);
    cmd(0, 0, 0);
    for (int s = 0; s < 2; s++) begin
      for (int rd = 0; rd < 4; rd++) begin
        rd_sel = rd[1:0];
        #1;
        vectors++;
        if (dout_o[s] !== 4'd0) begin
          miscompares++;
          $display("FAIL reset_dout inst=%0d rd=%0d got=%0d exp=0", s, rd, dout_o[s]);
        end
      end
      vectors++;
      if (zero_o[s] !== 3'b111 || atl_o[s] !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_status inst=%0d zero=%b at_limit=%b exp 111/000", s, zero_o[s], atl_o[s]);
      end
      vectors++;
      if (ovf_o[s] !== 0 || unf_o[s] !== 0 || err_o[s] !== 0) begin
        miscompares++;
        $display("FAIL reset_pulses inst=%0d ovf=%b unf=%b err=%b exp 0", s, ovf_o[s], unf_o[s], err_o[s]);
      end
    end
  endtask

  task automatic test_limit_load_incr();
    logic [DW-1:0] exp_after_incr [2];
    exp_after_incr[0] = 4'd0;
    exp_after_incr[1] = 4'd5;
    cmd(6, 1, 5);
    cmd(2, 1, 9);
    rd_sel = 2'd1;
    #1;
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (dout_o[s] !== 4'd5) begin
        miscompares++;
        $display("FAIL load_clamp inst=%0d got=%0d exp=5", s, dout_o[s]);
      end
    end
    cmd(3, 1, 0);
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (dout_o[s] !== exp_after_incr[s] || ovf_o[s] !== 3'b010) begin
        miscompares++;
        $display("FAIL incr_at_limit inst=%0d val=%0d ovf=%b exp val=%0d ovf=010",
                 s, dout_o[s], ovf_o[s], exp_after_incr[s]);
      end
    end
    cmd(0, 0, 0);
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (ovf_o[s] !== 3'b000) begin
        miscompares++;
        $display("FAIL ovf_one_cycle inst=%0d ovf=%b exp=000", s, ovf_o[s]);
      end
    end
  endtask

  task automatic test_decr_zero();
    logic [DW-1:0] exp_v [2];
    exp_v[0] = 4'd15;
    exp_v[1] = 4'd0;
    cmd(4, 0, 0);
    rd_sel = 2'd0;
    #1;
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (dout_o[s] !== exp_v[s] || unf_o[s] !== 3'b001) begin
        miscompares++;
        $display("FAIL decr_at_zero inst=%0d val=%0d unf=%b exp val=%0d unf=001",
                 s, dout_o[s], unf_o[s], exp_v[s]);
      end
    end
  endtask

  task automatic test_limit_clamp();
    cmd(2, 2, 12);
    cmd(6, 2, 7);
    for (int s = 0; s < 2; s++) begin
      rd_sel = 2'd2;
      #1;
      vectors++;
      if (dout_o[s] !== 4'd7 || atl_o[s][2] !== 1'b1) begin
        miscompares++;
        $display("FAIL set_limit_clamp inst=%0d val=%0d at_limit=%b exp val=7 bit2=1",
                 s, dout_o[s], atl_o[s]);
      end
      for (int rd = 0; rd < 2; rd++) begin
        rd_sel = rd[1:0];
        #1;
        vectors++;
        if (dout_o[s] !== exp_rd(s, rd)) begin
          miscompares++;
          $display("FAIL clamp_other_ch inst=%0d ch=%0d got=%0d exp=%0d", s, rd, dout_o[s], exp_rd(s, rd));
        end
      end
    end
  endtask

  task automatic test_sel_err();
    cmd(3, 3, 0);
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (err_o[s] !== 1'b1 || zero_o[s] !== exp_zero(s) || atl_o[s] !== exp_atl(s)) begin
        miscompares++;
        $display("FAIL sel_err_incr inst=%0d err=%b zero=%b exp err=1 zero=%b", s, err_o[s], zero_o[s], exp_zero(s));
      end
      for (int rd = 0; rd < CH; rd++) begin
        rd_sel = rd[1:0];
        #1;
        vectors++;
        if (dout_o[s] !== exp_rd(s, rd)) begin
          miscompares++;
          $display("FAIL sel_err_hold inst=%0d ch=%0d got=%0d exp=%0d", s, rd, dout_o[s], exp_rd(s, rd));
        end
      end
    end
    cmd(5, 3, 0);
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (err_o[s] !== 1'b0 || zero_o[s] !== 3'b111) begin
        miscompares++;
        $display("FAIL clr_all_oob inst=%0d err=%b zero=%b exp err=0 zero=111", s, err_o[s], zero_o[s]);
      end
    end
  endtask

  // Limit 0 pins the channel; consecutive INCRs keep ovf asserted.
  task automatic test_back_to_back();
    cmd(6, 0, 0);
    for (int n = 0; n < 3; n++) begin
      cmd(3, 0, 0);
      for (int s = 0; s < 2; s++) begin
        rd_sel = 2'd0;
        #1;
        vectors++;
        if (ovf_o[s] !== 3'b001 || dout_o[s] !== 4'd0) begin
          miscompares++;
          $display("FAIL b2b_ovf inst=%0d n=%0d ovf=%b val=%0d exp ovf=001 val=0", s, n, ovf_o[s], dout_o[s]);
        end
      end
    end
  endtask

  task automatic test_random(input int n_steps);
    int c, ch, d;
    for (int n = 0; n < n_steps; n++) begin
      c  = $urandom_range(0, 7);
      ch = $urandom_range(0, 3);
      d  = $urandom_range(0, 15);
      cmd(c, ch, d);
      for (int s = 0; s < 2; s++) begin
        vectors++;
        if (zero_o[s] !== exp_zero(s) || atl_o[s] !== exp_atl(s) ||
            ovf_o[s] !== m_ovf[s] || unf_o[s] !== m_unf[s] || err_o[s] !== m_err) begin
          miscompares++;
          $display("FAIL rand_status step=%0d inst=%0d cmd=%0d ch=%0d zero=%b/%b atl=%b/%b ovf=%b/%b unf=%b/%b err=%b/%b",
                   n, s, c, ch, zero_o[s], exp_zero(s), atl_o[s], exp_atl(s),
                   ovf_o[s], m_ovf[s], unf_o[s], m_unf[s], err_o[s], m_err);
        end
        for (int rd = 0; rd < 4; rd++) begin
          rd_sel = rd[1:0];
          #1;
          vectors++;
          if (dout_o[s] !== exp_rd(s, rd)) begin
            miscompares++;
            $display("FAIL rand_value step=%0d inst=%0d ch=%0d got=%0d exp=%0d", n, s, rd, dout_o[s], exp_rd(s, rd));
          end
        end
      end
    end
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < CH; k++) begin
      cmd(6, k, 15);
      cmd(2, k, 4 + k);
    end
    // mid-cycle, well away from any edge
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (zero_o[s] !== 3'b111 || atl_o[s] !== 3'b000 || ovf_o[s] !== 0 ||
          unf_o[s] !== 0 || err_o[s] !== 0) begin
        miscompares++;
        $display("FAIL async_rst_status inst=%0d zero=%b atl=%b ovf=%b unf=%b err=%b",
                 s, zero_o[s], atl_o[s], ovf_o[s], unf_o[s], err_o[s]);
      end
      for (int rd = 0; rd < CH; rd++) begin
        rd_sel = rd[1:0];
        #1;
        vectors++;
        if (dout_o[s] !== 4'd0) begin
          miscompares++;
          $display("FAIL async_rst_value inst=%0d ch=%0d got=%0d exp=0", s, rd, dout_o[s]);
        end
      end
    end
    @(negedge clk);
    rst = 1'b0;
    cmd(2, 1, 3);
    rd_sel = 2'd1;
    #1;
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if (dout_o[s] !== 4'd3) begin
        miscompares++;
        $display("FAIL post_reset_cmd inst=%0d got=%0d exp=3", s, dout_o[s]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_limit_load_incr();
    test_decr_zero();
    test_limit_clamp();
    test_sel_err();
    test_back_to_back();
    test_random(400);
    test_async_reset();
    test_random(100);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
